tnoc_packet_unpacker_packed: RTL and testbench

// - Next-gen flit->packet unpacker at the NoC/local-IF boundary. Collects 1..MAX_HEADER_FLITS header flits into one registered header.
// - Packs up to PACK_FLITS payload flits into one wide output beat. Detects framing errors.
// - Sits after the per-VC selector; one instance per selected VC stream.

---
 rtl/tnoc_unpack_pkg.sv | 21 ++
 rtl/tnoc_payload_packer.sv | 94 +++++++++
 rtl/tnoc_packet_unpacker_packed.sv | 169 ++++++++++++++++
 tb/tb_tnoc_packet_unpacker_packed.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnoc_unpack_pkg.sv
// tnoc_unpack_pkg: shared state type, packet-type decode and counter sizing for the flit->packet unpacker
package tnoc_unpack_pkg;

    typedef enum logic [1:0] {
        S_HEADER,
        S_HDR_OUT,
        S_PAYLOAD
    } tnoc_unpack_state_e;

    localparam int PTYPE_RESPONSE_BIT = 7;

    function automatic logic is_response_ptype(input logic [7:0] ptype);
        return ptype[PTYPE_RESPONSE_BIT];
    endfunction

    // Counters index a buffer of `depth` entries; a depth of 1 still gets one bit.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tnoc_payload_packer.sv
// tnoc_payload_packer: packs payload flits into one wide registered beat with a slot mask
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        accepted payload flit (the parent only raises it on a handshake)
//   in_tail/in_data tail flag and data of that flit
//   flush           discard the partially filled accumulator
//   in_ready        a flit may be taken this cycle (only a completing flit can be blocked)
//   out_*           registered beat: valid/ready, data, contiguous slot mask, packet tail
module tnoc_payload_packer
    import tnoc_unpack_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 256,
    parameter int PACK_FLITS      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic                                  in_tail,
    input  logic [FLIT_DATA_WIDTH-1:0]            in_data,
    input  logic                                  flush,
    output logic                                  in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [PACK_FLITS*FLIT_DATA_WIDTH-1:0] out_data,
    output logic [PACK_FLITS-1:0]                 out_mask,
    output logic                                  out_last
);
    localparam int FDW = FLIT_DATA_WIDTH;
    localparam int PCW = cnt_width(PACK_FLITS);

    logic [PCW-1:0]            pcnt_q, pcnt_d;
    logic [PACK_FLITS*FDW-1:0] acc_q, acc_d;
    logic                      out_valid_q, out_valid_d;
    logic [PACK_FLITS*FDW-1:0] out_data_q, out_data_d;
    logic [PACK_FLITS-1:0]     out_mask_q, out_mask_d;
    logic                      out_last_q, out_last_d;
    logic                      completing;
    logic [PACK_FLITS*FDW-1:0] beat_data;
    logic [PACK_FLITS-1:0]     beat_mask;

    assign completing = (pcnt_q == PCW'(PACK_FLITS - 1)) || in_tail;
    // Non-completing flits only enter the accumulator, so they never wait on the sink.
    assign in_ready   = !completing || !out_valid_q || out_ready;

    always_comb begin
        beat_data                    = acc_q;
        beat_data[pcnt_q*FDW +: FDW] = in_data;
        for (int k = 0; k < PACK_FLITS; k++) beat_mask[k] = PCW'(k) <= pcnt_q;
        pcnt_d      = pcnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        if (flush) begin
            acc_d  = '0;
            pcnt_d = '0;
        end else if (in_valid && completing) begin
            // Slots above the completing flit are still zero because acc is cleared on every completion.
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_mask_d  = beat_mask;
            out_last_d  = in_tail;
            acc_d       = '0;
            pcnt_d      = '0;
        end else if (in_valid) begin
            acc_d  = beat_data;
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q      <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign out_last  = out_last_q;

endmodule

// File: rtl/tnoc_packet_unpacker_packed.sv
// tnoc_packet_unpacker_packed: turns a flit stream into one registered header plus packed payload beats
//   clk, rst_n                    clock, asynchronous active-low reset
//   flit_valid/ready/head/tail    input flit handshake and framing
//   flit_data                     flit payload; packet type is data[7:0] of the head flit
//   header_valid/ready            registered header handshake
//   header_data                   header flit i at [i*FDW+:FDW], unfilled slots zero
//   header_has_payload            payload beats follow this header
//   header_error                  header cut short by an early tail
//   payload_valid/ready           packed beat handshake
//   payload_data/flit_mask/last   beat contents, filled-slot mask, packet tail
//   protocol_error                one-cycle pulse on a framing error
module tnoc_packet_unpacker_packed
    import tnoc_unpack_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH  = 256,
    parameter int REQ_HEADER_FLITS = 2,
    parameter int RSP_HEADER_FLITS = 1,
    parameter int MAX_HEADER_FLITS = 2,
    parameter int PACK_FLITS       = 2
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flit_valid,
    output logic                                        flit_ready,
    input  logic                                        flit_head,
    input  logic                                        flit_tail,
    input  logic [FLIT_DATA_WIDTH-1:0]                  flit_data,
    output logic                                        header_valid,
    input  logic                                        header_ready,
    output logic [MAX_HEADER_FLITS*FLIT_DATA_WIDTH-1:0] header_data,
    output logic                                        header_has_payload,
    output logic                                        header_error,
    output logic                                        payload_valid,
    input  logic                                        payload_ready,
    output logic [PACK_FLITS*FLIT_DATA_WIDTH-1:0]       payload_data,
    output logic [PACK_FLITS-1:0]                       payload_flit_mask,
    output logic                                        payload_last,
    output logic                                        protocol_error
);
    localparam int FDW = FLIT_DATA_WIDTH;
    localparam int HCW = cnt_width(MAX_HEADER_FLITS);

    tnoc_unpack_state_e              state_q, state_d;
    logic [HCW-1:0]                  hdr_cnt_q, hdr_cnt_d;
    logic [HCW-1:0]                  exp_m1_q, exp_m1_d;
    logic [MAX_HEADER_FLITS*FDW-1:0] hdr_buf_q, hdr_buf_d;
    logic                            header_valid_q, header_valid_d;
    logic                            has_payload_q, has_payload_d;
    logic                            header_error_q, header_error_d;
    logic                            protocol_error_q, protocol_error_d;
    logic [HCW-1:0]                  head_exp_m1, cur_exp_m1;
    logic                            hdr_done, hdr_path;
    logic                            pk_valid, pk_flush, pk_in_ready;

    // Header length comes from the head flit itself on slot 0, from the latched value afterwards.
    assign head_exp_m1 = is_response_ptype(flit_data[7:0]) ? HCW'(RSP_HEADER_FLITS - 1)
                                                           : HCW'(REQ_HEADER_FLITS - 1);
    assign cur_exp_m1  = (hdr_cnt_q == '0) ? head_exp_m1 : exp_m1_q;
    assign hdr_done    = (hdr_cnt_q == cur_exp_m1) || flit_tail;

    always_comb begin
        state_d          = state_q;
        hdr_cnt_d        = hdr_cnt_q;
        exp_m1_d         = exp_m1_q;
        hdr_buf_d        = hdr_buf_q;
        header_valid_d   = header_valid_q;
        has_payload_d    = has_payload_q;
        header_error_d   = header_error_q;
        protocol_error_d = 1'b0;
        flit_ready       = 1'b0;
        hdr_path         = 1'b0;
        pk_valid         = 1'b0;
        pk_flush         = 1'b0;
        unique case (state_q)
            S_HEADER: begin
                flit_ready = 1'b1;
                hdr_path   = flit_valid;
            end
            S_HDR_OUT: begin
                if (header_ready) begin
                    header_valid_d = 1'b0;
                    has_payload_d  = 1'b0;
                    header_error_d = 1'b0;
                    hdr_buf_d      = '0;
                    state_d        = header_has_payload ? S_PAYLOAD : S_HEADER;
                end
            end
            S_PAYLOAD: begin
                flit_ready = pk_in_ready;
                // A head here means the previous packet lost its tail: drop the partial beat
                // and decode this flit as a fresh header in the same cycle.
                if (flit_valid && pk_in_ready && flit_head) begin
                    protocol_error_d = 1'b1;
                    pk_flush         = 1'b1;
                    hdr_path         = 1'b1;
                end else if (flit_valid && pk_in_ready) begin
                    pk_valid = 1'b1;
                    state_d  = flit_tail ? S_HEADER : S_PAYLOAD;
                end
            end
            default: state_d = S_HEADER;
        endcase
        if (hdr_path) begin
            if (hdr_cnt_q == '0 && !flit_head) begin
                protocol_error_d = 1'b1;
            end else begin
                hdr_buf_d[hdr_cnt_q*FDW +: FDW] = flit_data;
                exp_m1_d                        = cur_exp_m1;
                if (hdr_done) begin
                    header_valid_d = 1'b1;
                    has_payload_d  = !flit_tail;
                    header_error_d = flit_tail && (hdr_cnt_q < cur_exp_m1);
                    hdr_cnt_d      = '0;
                    state_d        = S_HDR_OUT;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                    state_d   = S_HEADER;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_HEADER;
            hdr_cnt_q        <= '0;
            exp_m1_q         <= '0;
            hdr_buf_q        <= '0;
            header_valid_q   <= 1'b0;
            has_payload_q    <= 1'b0;
            header_error_q   <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            hdr_cnt_q        <= hdr_cnt_d;
            exp_m1_q         <= exp_m1_d;
            hdr_buf_q        <= hdr_buf_d;
            header_valid_q   <= header_valid_d;
            has_payload_q    <= has_payload_d;
            header_error_q   <= header_error_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign header_valid       = header_valid_q;
    assign header_data        = hdr_buf_q;
    assign header_has_payload = has_payload_q;
    assign header_error       = header_error_q;
    assign protocol_error     = protocol_error_q;

    tnoc_payload_packer #(
        .FLIT_DATA_WIDTH (FLIT_DATA_WIDTH),
        .PACK_FLITS      (PACK_FLITS)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (pk_valid),
        .in_tail   (flit_tail),
        .in_data   (flit_data),
        .flush     (pk_flush),
        .in_ready  (pk_in_ready),
        .out_valid (payload_valid),
        .out_ready (payload_ready),
        .out_data  (payload_data),
        .out_mask  (payload_flit_mask),
        .out_last  (payload_last)
    );

endmodule

// File: tb/tb_tnoc_packet_unpacker_packed.sv
// tb_tnoc_packet_unpacker_packed: directed table-driven bench for the flit->packet unpacker
module tb_tnoc_packet_unpacker_packed;
    localparam int FDW  = 256;
    localparam int PACK = 2;
    localparam int MAXH = 2;

    typedef struct {
        logic [7:0] ptype;
        int         n;
        logic       hstall;
        int         pmode;
        int         hslots;
        logic       err;
        logic       has_pl;
        int         beats;
        logic [1:0] lmask;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flit_valid = 1'b0, flit_head = 1'b0, flit_tail = 1'b0;
    logic [FDW-1:0]       flit_data = '0;
    logic                 flit_ready;
    logic                 header_valid, header_has_payload, header_error;
    logic                 header_ready = 1'b0;
    logic [MAXH*FDW-1:0]  header_data;
    logic                 payload_valid, payload_last, protocol_error;
    logic                 payload_ready = 1'b0;
    logic [PACK*FDW-1:0]  payload_data;
    logic [PACK-1:0]      payload_flit_mask;

    int checks = 0;
    int errors = 0;
    int nh, nb, np, exp_nh, exp_nb, exp_np, hold;
    logic hdr_stall = 1'b0;
    int   pay_mode = 0;
    logic mon_en = 1'b0;
    logic [511:0] eh_d[2];
    logic         eh_pl[2], eh_err[2];
    logic [511:0] eb_d[4];
    logic [1:0]   eb_m[4];
    logic         eb_l[4];
    logic hv_p = 1'b0, hr_p = 1'b0, pv_p = 1'b0, pr_p = 1'b0;
    vec_t vt[9];

    tnoc_packet_unpacker_packed #(
        .FLIT_DATA_WIDTH  (FDW),
        .REQ_HEADER_FLITS (2),
        .RSP_HEADER_FLITS (1),
        .MAX_HEADER_FLITS (MAXH),
        .PACK_FLITS       (PACK)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flit_valid         (flit_valid),
        .flit_ready         (flit_ready),
        .flit_head          (flit_head),
        .flit_tail          (flit_tail),
        .flit_data          (flit_data),
        .header_valid       (header_valid),
        .header_ready       (header_ready),
        .header_data        (header_data),
        .header_has_payload (header_has_payload),
        .header_error       (header_error),
        .payload_valid      (payload_valid),
        .payload_ready      (payload_ready),
        .payload_data       (payload_data),
        .payload_flit_mask  (payload_flit_mask),
        .payload_last       (payload_last),
        .protocol_error     (protocol_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FDW-1:0] mkf(input int id, input logic [7:0] pt);
        return {id[31:0], 216'd0, pt};
    endfunction

    // Header sink: optionally holds ready low for 5 cycles once a header appears.
    initial forever begin
        @(posedge clk);
        #1;
        if (hdr_stall && header_valid && hold < 5) begin
            header_ready = 1'b0;
            hold++;
        end else begin
            header_ready = 1'b1;
        end
    end

    // Payload sink: 0 always ready, 1 toggling, 2 never ready.
    initial forever begin
        @(posedge clk);
        #1;
        payload_ready = (pay_mode == 0) ? 1'b1 : (pay_mode == 1) ? ~payload_ready : 1'b0;
    end

    // Monitor on the falling edge: values seen here are what the next rising edge samples.
    initial forever begin
        @(negedge clk);
        if (rst_n && mon_en) begin
            if (hv_p && !hr_p) chk("hdr_valid_held", header_valid, 1'b1);
            if (pv_p && !pr_p) chk("pay_valid_held", payload_valid, 1'b1);
            if (header_valid) begin
                chk("flit_ready_in_hdr_out", flit_ready, 1'b0);
                if (nh < exp_nh) begin
                    chk("hdr_data", header_data, eh_d[nh]);
                    chk("hdr_has_payload", header_has_payload, eh_pl[nh]);
                    chk("hdr_error", header_error, eh_err[nh]);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_header: got header %0d expected %0d headers", nh + 1, exp_nh);
                end
                if (header_ready) nh++;
            end
            if (payload_valid) begin
                if (nb < exp_nb) begin
                    chk("beat_data", payload_data, eb_d[nb]);
                    chk("beat_mask", payload_flit_mask, eb_m[nb]);
                    chk("beat_last", payload_last, eb_l[nb]);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got beat %0d expected %0d beats", nb + 1, exp_nb);
                end
                if (payload_ready) nb++;
            end
            if (protocol_error) np++;
        end
        hv_p = header_valid;
        hr_p = header_ready;
        pv_p = payload_valid;
        pr_p = payload_ready;
    end

    task automatic send_flit(input logic h, input logic t, input logic [FDW-1:0] d);
        int n = 0;
        flit_valid = 1'b1;
        flit_head  = h;
        flit_tail  = t;
        flit_data  = d;
        @(negedge clk);
        while (!flit_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!flit_ready) begin
            checks++;
            errors++;
            $display("FAIL flit_accept_timeout: got flit_ready 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        flit_head  = 1'b0;
        flit_tail  = 1'b0;
    endtask

    task automatic clear_exp();
        nh = 0;
        nb = 0;
        np = 0;
        hold = 0;
        exp_np = 0;
        exp_nh = 1;
        exp_nb = 0;
        for (int i = 0; i < 2; i++) begin
            eh_d[i] = '0;
            eh_pl[i] = 1'b0;
            eh_err[i] = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            eb_d[b] = '0;
            eb_m[b] = 2'b11;
            eb_l[b] = 1'b0;
        end
    endtask

    task automatic finish_pkt(input string tag);
        int n = 0;
        while ((nh < exp_nh || nb < exp_nb) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_n_headers"}, nh, exp_nh);
        chk({tag, "_n_beats"}, nb, exp_nb);
        chk({tag, "_n_protocol_err"}, np, exp_np);
        chk({tag, "_idle_flit_ready"}, flit_ready, 1'b1);
        chk({tag, "_idle_hdr_valid"}, header_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int base, input string tag);
        logic [FDW-1:0] f;
        int j;
        clear_exp();
        hdr_stall = v.hstall;
        pay_mode  = v.pmode;
        eh_pl[0]  = v.has_pl;
        eh_err[0] = v.err;
        exp_nb    = v.beats;
        for (int b = 0; b < 4; b++) begin
            eb_m[b] = (b == v.beats - 1) ? v.lmask : 2'b11;
            eb_l[b] = (b == v.beats - 1);
        end
        for (int i = 0; i < v.n; i++) begin
            f = mkf(base + i, (i == 0) ? v.ptype : 8'hA5);
            if (i < v.hslots) begin
                eh_d[0][i*FDW +: FDW] = f;
            end else begin
                j = i - v.hslots;
                eb_d[j/PACK][(j%PACK)*FDW +: FDW] = f;
            end
        end
        for (int i = 0; i < v.n; i++)
            send_flit(i == 0, i == v.n - 1, mkf(base + i, (i == 0) ? v.ptype : 8'hA5));
        finish_pkt(tag);
    endtask

    initial begin
        // ptype, flits, hdr stall, pay mode, header slots, err, has_payload, beats, last mask
        vt[0] = '{8'h10, 6, 1'b0, 0, 2, 1'b0, 1'b1, 2, 2'b11};
        vt[1] = '{8'h90, 4, 1'b0, 0, 1, 1'b0, 1'b1, 2, 2'b01};
        vt[2] = '{8'h10, 5, 1'b1, 0, 2, 1'b0, 1'b1, 2, 2'b01};
        vt[3] = '{8'hFF, 6, 1'b0, 1, 1, 1'b0, 1'b1, 3, 2'b01};
        vt[4] = '{8'h10, 1, 1'b0, 0, 1, 1'b1, 1'b0, 0, 2'b00};
        vt[5] = '{8'h90, 1, 1'b0, 0, 1, 1'b0, 1'b0, 0, 2'b00};
        vt[6] = '{8'h7F, 2, 1'b0, 0, 2, 1'b0, 1'b0, 0, 2'b00};
        vt[7] = '{8'h7F, 3, 1'b0, 1, 2, 1'b0, 1'b1, 1, 2'b01};
        vt[8] = '{8'h85, 9, 1'b0, 1, 1, 1'b0, 1'b1, 4, 2'b11};
        clear_exp();
        repeat (3) @(posedge clk);
        #2;
        chk("in_reset_hdr_valid", header_valid, 1'b0);
        chk("in_reset_pay_valid", payload_valid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_flit_ready", flit_ready, 1'b1);
        chk("reset_hdr_valid", header_valid, 1'b0);
        chk("reset_hdr_data", header_data, '0);
        chk("reset_hdr_flags", {header_has_payload, header_error}, 2'b00);
        chk("reset_pay_valid", payload_valid, 1'b0);
        chk("reset_pay_data", payload_data, '0);
        chk("reset_pay_mask_last", {payload_flit_mask, payload_last}, 3'b000);
        chk("reset_protocol_error", protocol_error, 1'b0);
        mon_en = 1'b1;

        for (int v = 0; v < 9; v++) run_vec(vt[v], 100 + v * 16, $sformatf("vec%0d", v));

        // Header latency: header_valid rises one cycle after the last header flit handshake.
        clear_exp();
        hdr_stall = 1'b0;
        pay_mode  = 0;
        eh_d[0]   = {mkf(501, 8'hA5), mkf(500, 8'h10)};
        send_flit(1'b1, 1'b0, mkf(500, 8'h10));
        chk("hdr_lat_before", header_valid, 1'b0);
        send_flit(1'b0, 1'b1, mkf(501, 8'hA5));
        chk("hdr_lat_after", header_valid, 1'b1);
        finish_pkt("hdr_latency");

        // Beat latency: beat valid one cycle after the completing flit.
        clear_exp();
        eh_d[0]  = {256'd0, mkf(600, 8'h90)};
        eh_pl[0] = 1'b1;
        exp_nb   = 1;
        eb_d[0]  = {mkf(602, 8'hA5), mkf(601, 8'hA5)};
        eb_l[0]  = 1'b1;
        send_flit(1'b1, 1'b0, mkf(600, 8'h90));
        send_flit(1'b0, 1'b0, mkf(601, 8'hA5));
        chk("beat_lat_before", payload_valid, 1'b0);
        send_flit(1'b0, 1'b1, mkf(602, 8'hA5));
        chk("beat_lat_after", {payload_valid, payload_last}, 2'b11);
        finish_pkt("beat_latency");

        // Head mid-payload: partial beat dropped, new header decoded in the same cycle.
        clear_exp();
        exp_nh    = 2;
        exp_np    = 1;
        eh_d[0]   = {mkf(301, 8'hA5), mkf(300, 8'h10)};
        eh_pl[0]  = 1'b1;
        eh_d[1]   = {256'd0, mkf(303, 8'h90)};
        eh_pl[1]  = 1'b1;
        exp_nb    = 1;
        eb_d[0]   = {mkf(305, 8'hA5), mkf(304, 8'hA5)};
        eb_l[0]   = 1'b1;
        send_flit(1'b1, 1'b0, mkf(300, 8'h10));
        send_flit(1'b0, 1'b0, mkf(301, 8'hA5));
        send_flit(1'b0, 1'b0, mkf(302, 8'hA5));
        send_flit(1'b1, 1'b0, mkf(303, 8'h90));
        send_flit(1'b0, 1'b0, mkf(304, 8'hA5));
        send_flit(1'b0, 1'b1, mkf(305, 8'hA5));
        finish_pkt("head_mid_payload");

        // Non-head flit while waiting for a header is dropped with an error pulse.
        clear_exp();
        exp_np  = 1;
        eh_d[0] = {256'd0, mkf(401, 8'h90)};
        send_flit(1'b0, 1'b0, mkf(400, 8'h10));
        send_flit(1'b1, 1'b1, mkf(401, 8'h90));
        finish_pkt("stray_body");

        // Asynchronous reset with a beat pending and a partial beat in the accumulator.
        clear_exp();
        pay_mode = 2;
        eh_d[0]  = {mkf(701, 8'hA5), mkf(700, 8'h10)};
        eh_pl[0] = 1'b1;
        exp_nb   = 1;
        eb_d[0]  = {mkf(703, 8'hA5), mkf(702, 8'hA5)};
        for (int i = 0; i < 5; i++) send_flit(i == 0, 1'b0, mkf(700 + i, (i == 0) ? 8'h10 : 8'hA5));
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_pay_valid", payload_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pay_valid", payload_valid, 1'b0);
        chk("async_rst_pay_data", payload_data, '0);
        chk("async_rst_pay_mask_last", {payload_flit_mask, payload_last}, 3'b000);
        chk("async_rst_hdr", {header_valid, header_has_payload, header_error, protocol_error}, 4'b0000);
        chk("async_rst_hdr_data", header_data, '0);
        chk("async_rst_flit_ready", flit_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vt[1], 800, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
